// File: rtl/char_gen_text_if.sv
// char_gen_text_if: text RAM and font ROM read bus of the text-mode pixel generator
interface char_gen_text_if #(
   parameter int AW      = 12,
   parameter int CODE_W  = 7,
   parameter int FAW     = 11,
   parameter int GLYPH_W = 8
);
   logic [AW-1:0]      text_addr;
   logic [CODE_W-1:0]  text_data;
   logic [FAW-1:0]     font_addr;
   logic [GLYPH_W-1:0] font_data;
   modport master (output text_addr, font_addr, input text_data, font_data);
   modport slave  (input text_addr, font_addr, output text_data, font_data);
endinterface

// File: rtl/char_gen_text.sv
// char_gen_text: 5-stage text-mode pixel generator with text RAM/font ROM lookup and blinking cursor
module char_gen_text #(
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int GLYPH_W      = 8,
   parameter int GLYPH_H      = 12,
   parameter int COLS         = 80,
   parameter int ROWS         = 40,
   parameter int CODE_W       = 7,
   parameter int MSB_FIRST    = 1,
   parameter int CURSOR_MODE  = 0,
   parameter int BLINK_FRAMES = 30
) (
   input  logic             clock25,
   input  logic             reset_n,
   input  logic [9:0]       HorizontalCounter,
   input  logic [9:0]       VerticalCounter,
   input  logic             cursor_en,
   input  logic [6:0]       cursor_col,
   input  logic [5:0]       cursor_row,
   char_gen_text_if.master  mem,
   output logic             Pixel,
   output logic             pixel_valid
);
   localparam int AW  = $clog2(COLS*ROWS);
   localparam int FAW = CODE_W + $clog2(GLYPH_H);
   localparam int LW  = GLYPH_H > 1 ? $clog2(GLYPH_H) : 1;
   localparam int BW  = $clog2(GLYPH_W);
   localparam int FW  = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

   if (COLS*GLYPH_W > H_ACTIVE || ROWS*GLYPH_H > V_ACTIVE) begin : g_bad_geometry
      $error("char_gen_text: text area exceeds the visible area");
   end

   typedef struct packed {
      logic          act;
      logic          hit;
      logic [LW-1:0] line;
      logic [BW-1:0] bit_i;
   } stage_t;

   stage_t        pipe [4];
   logic [9:0]    col, row;
   logic [LW-1:0] line;
   logic          act, hit, frame_tick, phase, glyph, pix_next;
   logic [FW-1:0] frame_cnt;
   logic [BW-1:0] sel;

   assign col        = HorizontalCounter >> BW;
   assign row        = VerticalCounter / 10'(GLYPH_H);
   assign line       = LW'(VerticalCounter % 10'(GLYPH_H));
   assign act        = (32'(HorizontalCounter) < COLS*GLYPH_W) && (32'(VerticalCounter) < ROWS*GLYPH_H);
   assign hit        = act && cursor_en && phase && col == 10'(cursor_col) && row == 10'(cursor_row);
   assign frame_tick = VerticalCounter == 10'(V_ACTIVE) && HorizontalCounter == '0;
   assign sel        = MSB_FIRST != 0 ? BW'(GLYPH_W-1) - pipe[3].bit_i : pipe[3].bit_i;
   assign glyph      = mem.font_data[sel];
   assign pix_next   = CURSOR_MODE == 0 ? glyph ^ pipe[3].hit
                                        : glyph | (pipe[3].hit && pipe[3].line == LW'(GLYPH_H-1));

   // blink phase: toggles every BLINK_FRAMES frame ticks, held visible when BLINK_FRAMES is 0
   always_ff @(posedge clock25 or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt <= '0;
         phase     <= 1'b1;
      end else if (frame_tick && BLINK_FRAMES != 0) begin
         if (32'(frame_cnt) == BLINK_FRAMES-1) begin
            frame_cnt <= '0;
            phase     <= ~phase;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   // stage pipeline: addresses update only for text-area samples, pixel is masked outside it
   always_ff @(posedge clock25 or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) pipe[i] <= '0;
         mem.text_addr <= '0;
         mem.font_addr <= '0;
         Pixel         <= 1'b0;
         pixel_valid   <= 1'b0;
      end else begin
         pipe[0] <= {act, hit, line, HorizontalCounter[BW-1:0]};
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
         if (act) mem.text_addr <= AW'(32'(row)*COLS + 32'(col));
         if (pipe[1].act) mem.font_addr <= FAW'(32'(mem.text_data)*GLYPH_H + 32'(pipe[1].line));
         Pixel       <= pipe[3].act && pix_next;
         pixel_valid <= pipe[3].act;
      end
   end
endmodule

// File: tb/tb_char_gen_text.sv
// tb_char_gen_text: directed and random checks of two char_gen_text variants against a raster-rule model
module tb_char_gen_text;
   typedef struct packed {
      logic        act;
      logic [11:0] ta;
      logic [10:0] fa;
      logic        pix;
   } rec_t;

   logic       clock25 = 1'b0;
   logic       reset_n = 1'b0;
   logic [9:0] hc = '0, vc = '0;
   logic       cen = 1'b0;
   logic [6:0] ccol = '0;
   logic [5:0] crow = '0;
   logic       pix0, pv0, pix1, pv1;
   logic [6:0] text_mem [4096];
   logic [7:0] font_mem [2048];
   rec_t       q0[$], q1[$];
   logic [11:0] eta0, eta1;
   logic [10:0] efa0, efa1;
   int         tk0, tk1;
   int         checks = 0, errors = 0;

   char_gen_text_if if0 ();
   char_gen_text_if if1 ();

   always #20 clock25 = ~clock25;

   char_gen_text #(.BLINK_FRAMES(0)) u0 (
      .clock25(clock25), .reset_n(reset_n), .HorizontalCounter(hc), .VerticalCounter(vc),
      .cursor_en(cen), .cursor_col(ccol), .cursor_row(crow), .mem(if0.master),
      .Pixel(pix0), .pixel_valid(pv0));

   char_gen_text #(.ROWS(30), .MSB_FIRST(0), .CURSOR_MODE(1), .BLINK_FRAMES(2)) u1 (
      .clock25(clock25), .reset_n(reset_n), .HorizontalCounter(hc), .VerticalCounter(vc),
      .cursor_en(cen), .cursor_col(ccol), .cursor_row(crow), .mem(if1.master),
      .Pixel(pix1), .pixel_valid(pv1));

   // synchronous one-cycle text RAM and font ROM behind each instance
   always @(posedge clock25) begin
      if0.text_data <= text_mem[if0.text_addr];
      if0.font_data <= font_mem[if0.font_addr];
      if1.text_data <= text_mem[if1.text_addr];
      if1.font_data <= font_mem[if1.font_addr];
   end

   function automatic rec_t model(int cols, int rows, bit msb, bit mode, int bf, int tk, int h, int v);
      rec_t r;
      int col, row, line, b, code;
      logic [7:0] g;
      bit gb, ph, hit;
      col   = h / 8;
      row   = v / 12;
      line  = v % 12;
      b     = h % 8;
      r.act = (h < cols*8) && (v < rows*12);
      r.ta  = 12'(row*cols + col);
      code  = int'(text_mem[r.ta]);
      r.fa  = 11'(code*12 + line);
      g     = font_mem[r.fa];
      gb    = msb ? g[7-b] : g[b];
      ph    = (bf == 0) || ((tk / bf) % 2 == 0);
      hit   = cen && col == int'(ccol) && row == int'(crow) && ph && r.act;
      r.pix = r.act && (mode ? (gb || (hit && line == 11)) : (gb ^ hit));
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic restart();
      q0.delete();
      q1.delete();
      repeat (4) begin
         q0.push_back('0);
         q1.push_back('0);
      end
      eta0 = '0; eta1 = '0; efa0 = '0; efa1 = '0;
      tk0 = 0; tk1 = 0;
   endtask

   task automatic chk_reset();
      chk("rst_pixel0", 32'(pix0), 0);
      chk("rst_valid0", 32'(pv0), 0);
      chk("rst_taddr0", 32'(if0.text_addr), 0);
      chk("rst_faddr0", 32'(if0.font_addr), 0);
      chk("rst_pixel1", 32'(pix1), 0);
      chk("rst_valid1", 32'(pv1), 0);
      chk("rst_taddr1", 32'(if1.text_addr), 0);
      chk("rst_faddr1", 32'(if1.font_addr), 0);
   endtask

   task automatic step(input int h, input int v);
      rec_t r;
      @(negedge clock25);
      hc = 10'(h);
      vc = 10'(v);
      q0.push_back(model(80, 40, 1'b1, 1'b0, 0, tk0, h, v));
      q1.push_back(model(80, 30, 1'b0, 1'b1, 2, tk1, h, v));
      if (h == 0 && v == 480) begin
         tk0++;
         tk1++;
      end
      @(posedge clock25);
      #1;
      if (q0[4].act) eta0 = q0[4].ta;
      if (q0[2].act) efa0 = q0[2].fa;
      if (q1[4].act) eta1 = q1[4].ta;
      if (q1[2].act) efa1 = q1[2].fa;
      r = q0.pop_front();
      chk("u0_pixel", 32'(pix0), 32'(r.pix));
      chk("u0_valid", 32'(pv0), 32'(r.act));
      chk("u0_text_addr", 32'(if0.text_addr), 32'(eta0));
      chk("u0_font_addr", 32'(if0.font_addr), 32'(efa0));
      r = q1.pop_front();
      chk("u1_pixel", 32'(pix1), 32'(r.pix));
      chk("u1_valid", 32'(pv1), 32'(r.act));
      chk("u1_text_addr", 32'(if1.text_addr), 32'(eta1));
      chk("u1_font_addr", 32'(if1.font_addr), 32'(efa1));
   endtask

   task automatic flush();
      repeat (5) step(700, 0);
   endtask

   initial begin
      int h, v;
      for (int i = 0; i < 4096; i++) text_mem[i] = 7'($urandom);
      for (int i = 0; i < 2048; i++) font_mem[i] = 8'h81;
      repeat (2) @(posedge clock25);
      #1;
      chk_reset();
      @(posedge clock25);
      #5 reset_n = 1'b1;
      restart();
      // edge columns of every glyph row lit
      for (int x = 0; x < 8; x++) step(x, 0);
      flush();
      // address mapping and text-area boundaries
      step(8, 13);
      step(639, 479);
      step(640, 0);
      step(700, 200);
      step(300, 490);
      step(300, 400);
      step(799, 524);
      step(0, 359);
      step(0, 360);
      flush();
      // random raster samples with random glyphs and cursor positions
      for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
      for (int n = 0; n < 600; n++) begin
         h = int'($urandom_range(0, 799));
         v = int'($urandom_range(0, 524));
         cen = 1'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            ccol = 7'(h / 8);
            crow = 6'(v / 12);
         end else begin
            ccol = 7'($urandom_range(0, 90));
            crow = 6'($urandom_range(0, 45));
         end
         step(h, v);
         if (n % 40 == 0) step(0, 480);
      end
      flush();
      // asynchronous reset in the middle of an active line
      cen = 1'b0;
      for (int x = 90; x <= 100; x++) step(x, 5);
      #5 reset_n = 1'b0;
      #1;
      chk_reset();
      hc = 10'd700;
      repeat (2) @(posedge clock25);
      #5 reset_n = 1'b1;
      restart();
      for (int x = 101; x <= 140; x++) step(x, 5);
      flush();
      // cursor cell on a blank font
      for (int i = 0; i < 2048; i++) font_mem[i] = 8'h00;
      cen = 1'b1;
      ccol = 7'd2;
      crow = 6'd0;
      for (int y = 0; y <= 12; y++)
         for (int x = 8; x < 32; x++) step(x, y);
      // blink over five frames
      ccol = 7'd0;
      for (int f = 0; f < 5; f++) begin
         for (int x = 0; x < 8; x++) step(x, 11);
         step(0, 480);
         step(1, 480);
      end
      // out-of-range cursor never hits
      ccol = 7'd85;
      crow = 6'd2;
      for (int x = 632; x < 640; x++) step(x, 35);
      flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
